// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard control: load-use bubble, taken-branch flush and a mult/div freeze FSM.
// Optional stall statistic counter and StallCount port enabled by defining HAZARD_STALL_COUNT_EN.
module id_ex_hazard_ctrl #(
    parameter int MULDIV_LAT = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] IFID_rs,
    input  logic [4:0] IFID_rt,
    input  logic       IFID_useRt,
    input  logic [4:0] IDEX_rt,
    input  logic       IDEX_MemRead,
    input  logic       MulDiv_start,
    input  logic       Branch_taken,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IDEX_Write,
    output logic       IDEX_Bubble,
    output logic       IFID_Flush,
    output logic       Busy
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [31:0] StallCount
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_e;

    // Entry and release cycles are not counted, hence LAT-2 frozen MULDIV cycles.
    localparam logic [4:0] CNT_INIT = 5'(MULDIV_LAT - 2);

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       load_use;

    assign load_use = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                      ((IDEX_rt == IFID_rs) || (IFID_useRt && (IDEX_rt == IFID_rt)));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (!Branch_taken && MulDiv_start) begin
                    state_d = MULDIV;
                    cnt_d   = CNT_INIT;
                end
            end
            MULDIV: begin
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEX_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        Busy        = 1'b0;
        if (Reset) begin
            // Drain the pipeline to nops while reset is held.
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            IFID_Flush  = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (Branch_taken) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Bubble = 1'b1;
                    end else if (MulDiv_start) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEX_Write = 1'b0;
                    end else if (load_use) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end
                end
                MULDIV: begin
                    Busy = 1'b1;
                    if (cnt_q != 5'd0) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEX_Write = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= 32'd0;
        end else if (!PCWrite && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl: two instances (MULDIV_LAT=4 and 2) share stimulus.
// Control vector order: {PCWrite, IFIDWrite, IDEX_Write, IDEX_Bubble, IFID_Flush}.
module tb_id_ex_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [4:0] IFID_rs = '0, IFID_rt = '0, IDEX_rt = '0;
    logic       IFID_useRt = 1'b0, IDEX_MemRead = 1'b0, MulDiv_start = 1'b0, Branch_taken = 1'b0;

    logic a_pc, a_ifid, a_idexw, a_bub, a_flush, a_busy;
    logic b_pc, b_ifid, b_idexw, b_bub, b_flush, b_busy;
`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] a_stall, b_stall;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] DEF   = 5'b11100;
    localparam logic [4:0] RST   = 5'b00111;
    localparam logic [4:0] LUS   = 5'b00110;
    localparam logic [4:0] BRF   = 5'b11111;
    localparam logic [4:0] FRZ   = 5'b00000;

    logic [4:0] ctl_a, ctl_b;
    assign ctl_a = {a_pc, a_ifid, a_idexw, a_bub, a_flush};
    assign ctl_b = {b_pc, b_ifid, b_idexw, b_bub, b_flush};

    always #5 Clk = ~Clk;

    id_ex_hazard_ctrl #(.MULDIV_LAT(4)) u_dut_a (
        .Clk(Clk), .Reset(Reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_useRt(IFID_useRt),
        .IDEX_rt(IDEX_rt), .IDEX_MemRead(IDEX_MemRead), .MulDiv_start(MulDiv_start),
        .Branch_taken(Branch_taken), .PCWrite(a_pc), .IFIDWrite(a_ifid), .IDEX_Write(a_idexw),
        .IDEX_Bubble(a_bub), .IFID_Flush(a_flush), .Busy(a_busy)
`ifdef HAZARD_STALL_COUNT_EN
        , .StallCount(a_stall)
`endif
    );

    id_ex_hazard_ctrl #(.MULDIV_LAT(2)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_useRt(IFID_useRt),
        .IDEX_rt(IDEX_rt), .IDEX_MemRead(IDEX_MemRead), .MulDiv_start(MulDiv_start),
        .Branch_taken(Branch_taken), .PCWrite(b_pc), .IFIDWrite(b_ifid), .IDEX_Write(b_idexw),
        .IDEX_Bubble(b_bub), .IFID_Flush(b_flush), .Busy(b_busy)
`ifdef HAZARD_STALL_COUNT_EN
        , .StallCount(b_stall)
`endif
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                         input logic [4:0] ex_rt, input logic mem_rd, input logic md,
                         input logic br);
        IFID_rs      = rs;
        IFID_rt      = rt;
        IFID_useRt   = use_rt;
        IDEX_rt      = ex_rt;
        IDEX_MemRead = mem_rd;
        MulDiv_start = md;
        Branch_taken = br;
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ctl_a !== RST || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_a: got ctl=%b busy=%b exp ctl=%b busy=0", ctl_a, a_busy, RST);
        end
        checks++;
        if (ctl_b !== RST || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_b: got ctl=%b busy=%b exp ctl=%b busy=0", ctl_b, b_busy, RST);
        end
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ctl_a !== DEF || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_default: got ctl=%b busy=%b exp ctl=%b busy=0", ctl_a, a_busy, DEF);
        end
    endtask

    task automatic test_load_use();
        tick();
        drive(8, 0, 0, 8, 1, 0, 0);
        checks++;
        if (ctl_a !== LUS) begin
            errors++;
            $display("FAIL load_use_rs: got %b exp %b", ctl_a, LUS);
        end
        tick();
        drive(8, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ctl_a !== DEF) begin
            errors++;
            $display("FAIL load_use_after_bubble: got %b exp %b", ctl_a, DEF);
        end
        tick();
        drive(0, 0, 1, 0, 1, 0, 0);
        checks++;
        if (ctl_a !== DEF) begin
            errors++;
            $display("FAIL load_use_r0: got %b exp %b", ctl_a, DEF);
        end
        tick();
        drive(3, 9, 0, 9, 1, 0, 0);
        checks++;
        if (ctl_a !== DEF) begin
            errors++;
            $display("FAIL load_use_rt_unused: got %b exp %b", ctl_a, DEF);
        end
        tick();
        drive(3, 9, 1, 9, 1, 0, 0);
        checks++;
        if (ctl_a !== LUS || ctl_b !== LUS) begin
            errors++;
            $display("FAIL load_use_rt_used: got a=%b b=%b exp %b", ctl_a, ctl_b, LUS);
        end
        tick();
        drive(3, 9, 1, 10, 1, 0, 0);
        checks++;
        if (ctl_a !== DEF) begin
            errors++;
            $display("FAIL load_use_no_match: got %b exp %b", ctl_a, DEF);
        end
    endtask

    task automatic test_muldiv();
        // Cycle 1: entry, both instances frozen, not yet busy.
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (ctl_a !== FRZ || a_busy !== 1'b0 || ctl_b !== FRZ || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL muldiv_entry: got a=%b/%b b=%b/%b exp %b/0", ctl_a, a_busy, ctl_b, b_busy, FRZ);
        end
        // Cycle 2: LAT4 frozen and busy; LAT2 releases.
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (ctl_a !== FRZ || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL muldiv4_c2: got %b/%b exp %b/1", ctl_a, a_busy, FRZ);
        end
        checks++;
        if (ctl_b !== DEF || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL muldiv2_release: got %b/%b exp %b/1", ctl_b, b_busy, DEF);
        end
        // Cycle 3: branch and load-use ignored by LAT4 in MULDIV; LAT2 back in RUN takes branch.
        tick();
        drive(8, 0, 0, 8, 1, 0, 1);
        checks++;
        if (ctl_a !== FRZ || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL muldiv4_c3_ignore: got %b/%b exp %b/1", ctl_a, a_busy, FRZ);
        end
        checks++;
        if (ctl_b !== BRF || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL muldiv2_after_run: got %b/%b exp %b/0", ctl_b, b_busy, BRF);
        end
        // Cycle 4: LAT4 release.
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ctl_a !== DEF || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL muldiv4_release: got %b/%b exp %b/1", ctl_a, a_busy, DEF);
        end
        // Cycle 5: RUN again; load-use evaluated normally.
        tick();
        drive(8, 0, 0, 8, 1, 0, 0);
        checks++;
        if (ctl_a !== LUS || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL muldiv4_then_lu: got %b/%b exp %b/0", ctl_a, a_busy, LUS);
        end
    endtask

    task automatic test_branch_priority();
        tick();
        drive(8, 0, 0, 8, 1, 1, 1);
        checks++;
        if (ctl_a !== BRF || a_busy !== 1'b0 || ctl_b !== BRF) begin
            errors++;
            $display("FAIL branch_priority: got a=%b/%b b=%b exp %b/0", ctl_a, a_busy, ctl_b, BRF);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ctl_a !== DEF || a_busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL branch_no_muldiv: got a=%b/%b b_busy=%b exp %b/0", ctl_a, a_busy, b_busy, DEF);
        end
    endtask

    task automatic test_reset_mid_muldiv();
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ctl_a !== FRZ || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_cnt1: got %b/%b exp %b/1", ctl_a, a_busy, FRZ);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (ctl_a !== RST || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mid: got %b/%b exp %b/0", ctl_a, a_busy, RST);
        end
        Reset = 1'b0;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ctl_a !== DEF || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_mid: got %b/%b exp %b/0", ctl_a, a_busy, DEF);
        end
    endtask

`ifdef HAZARD_STALL_COUNT_EN
    task automatic test_stall_count();
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        checks++;
        if (a_stall !== 32'd0) begin
            errors++;
            $display("FAIL stall_cnt_reset: got %0d exp 0", a_stall);
        end
        Reset = 1'b0;
        tick();
        drive(8, 0, 0, 8, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        checks++;
        if (a_stall !== 32'd4) begin
            errors++;
            $display("FAIL stall_cnt_lat4: got %0d exp 4", a_stall);
        end
        checks++;
        if (b_stall !== 32'd2) begin
            errors++;
            $display("FAIL stall_cnt_lat2: got %0d exp 2", b_stall);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (a_stall !== 32'd0 || b_stall !== 32'd0) begin
            errors++;
            $display("FAIL stall_cnt_clear: got a=%0d b=%0d exp 0", a_stall, b_stall);
        end
        Reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_muldiv();
        test_branch_priority();
        test_reset_mid_muldiv();
`ifdef HAZARD_STALL_COUNT_EN
        test_stall_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_ctrl.md
# id_ex_hazard_ctrl

Pipeline-control block that drives the write enables, bubble insertion and flush of the IF/ID and ID/EX pipeline registers. It reads the decode-stage source fields and the EX-side fields leaving the ID/EX register (load destination, mult/div flag, resolved branch), and decides each cycle whether the front end advances, holds or is flushed. A small FSM with a down-counter freezes the pipeline while a multi-cycle multiply/divide occupies EX; load-use stalls and branch flushes are decided combinationally from the current state and inputs.

## Interface
- MULDIV_LAT, 4: total cycles a mult/div occupies EX; legal range 2..31.
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- IFID_rs  in  5  rs field of the instruction in decode.
- IFID_rt  in  5  rt field of the instruction in decode.
- IFID_useRt  in  1  decode instruction reads rt as a source.
- IDEX_rt  in  5  rt of the instruction currently in EX (ID/EX output).
- IDEX_MemRead  in  1  instruction in EX is a load.
- MulDiv_start  in  1  instruction in EX is mult/div.
- Branch_taken  in  1  branch resolved taken in EX this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register write enable.
- IDEX_Write  out  1  ID/EX register write enable.
- IDEX_Bubble  out  1  ID/EX loads zeroed WB/M/EX control bundles.
- IFID_Flush  out  1  IF/ID loads a nop.
- Busy  out  1  FSM is in MULDIV.
- StallCount  out  32  stall statistic (only with HAZARD_STALL_COUNT_EN).

## Operation
- States: RUN, MULDIV. Counter cnt, 5 bits.
- Load-use hazard LU = IDEX_MemRead & (IDEX_rt != 0) & ((IDEX_rt == IFID_rs) | (IFID_useRt & IDEX_rt == IFID_rt)).
- Defaults: PCWrite=1, IFIDWrite=1, IDEX_Write=1, IDEX_Bubble=0, IFID_Flush=0.
- RUN, priority order:
  - Branch_taken: IFID_Flush=1, IDEX_Bubble=1, write enables 1; stay RUN.
  - else MulDiv_start: PCWrite=0, IFIDWrite=0, IDEX_Write=0; next MULDIV, cnt <= MULDIV_LAT-2.
  - else LU: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IDEX_Write=1; stay RUN (exactly one bubble).
  - else defaults.
- MULDIV: Busy=1; Branch_taken, LU and MulDiv_start ignored.
  - cnt != 0: PCWrite=IFIDWrite=IDEX_Write=0; cnt <= cnt-1.
  - cnt == 0: release cycle, defaults; next RUN.
- Mult/div occupies EX for exactly MULDIV_LAT cycles: entry + (MULDIV_LAT-2) frozen + release.
- MULDIV_LAT=2: entry cycle frozen, next cycle release, no frozen MULDIV cycles.
- Register 0 never produces a load-use stall.

## Timing
- Outputs combinational from state, cnt and inputs; state and cnt update on rising Clk.
- Reset asserted (asynchronous, any time, including mid-MULDIV): state=RUN, cnt=0, Busy=0, StallCount=0; while asserted PCWrite=0, IFIDWrite=0, IDEX_Write=1, IDEX_Bubble=1, IFID_Flush=1 (pipeline drains to nops).
- First rising edge after Reset deasserts: normal RUN evaluation.
- Load-use: 1 stall cycle; load-use directly after a mult/div release is evaluated normally in the following RUN cycle.
- Simultaneous Branch_taken and MulDiv_start in RUN: branch wins, no MULDIV entry.

## Configuration
- HAZARD_STALL_COUNT_EN defined: StallCount port present; increments by 1 on each rising edge where Reset=0 and PCWrite=0; saturates at 0xFFFFFFFF; cleared only by Reset.
- Not defined: StallCount port and its register absent; all other behaviour identical.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_rt=8, IFID_rs=8 -> one cycle PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; with IDEX_rt=0 -> no stall.
- rt check: IDEX_MemRead=1, IDEX_rt=9, IFID_rt=9, IFID_useRt=0 -> no stall; IFID_useRt=1 -> one-cycle stall.
- Mult/div, MULDIV_LAT=4: MulDiv_start=1 held -> 3 cycles all write enables 0 (Busy=1 on cycles 2-3), 4th cycle enables 1, then RUN; same with MULDIV_LAT=2 -> 1 frozen cycle.
- Branch_taken=1 with LU=1 and MulDiv_start=1 -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, Busy stays 0.
- Reset asserted at cnt=1 in MULDIV -> immediately Busy=0, reset output values; after release, MulDiv_start=0 gives defaults.
- With HAZARD_STALL_COUNT_EN: one load-use stall plus MULDIV_LAT=4 sequence -> StallCount=4; Reset -> 0.
